// File: rtl/raytrace_frame_ctrl.sv
// raytrace_frame_ctrl: raster pixel issue to the ray core, credit-throttled result FIFO, framebuffer drain.
module raytrace_frame_ctrl #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int Z_PLANE      = 31,
   parameter int CORE_LATENCY = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_W       = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pix_valid,
   output logic [9:0]        pix_x,
   output logic [8:0]        pix_y,
   output logic [5:0]        pix_z,
   input  logic              core_ltz,
   output logic              fb_we,
   input  logic              fb_ready,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_data
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + CORE_LATENCY + 1);
   state_t state, state_nx;
   logic [CORE_LATENCY-1:0] vsr;
   logic [ADDR_W-1:0] asr [CORE_LATENCY];
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_count, inflight;
   logic push, pop, empty, full, last_pix, x_wrap;
   always_comb begin
      inflight = '0;
      for (int i = 0; i < CORE_LATENCY; i++) inflight = inflight + CW'(vsr[i]);
   end
   assign empty     = fifo_count == '0;
   assign full      = fifo_count == CW'(FIFO_DEPTH);
   assign push      = vsr[CORE_LATENCY-1];
   assign pop       = !empty && fb_ready;
   assign fb_we     = !empty;
   assign fb_addr   = empty ? '0 : mem[rd_ptr][ADDR_W:1];
   assign fb_data   = !empty && mem[rd_ptr][0];
   // Credits: every in-flight pixel already owns a FIFO slot, so a stalled drain never overflows.
   assign pix_valid = state == ISSUE && (fifo_count + inflight) < CW'(FIFO_DEPTH);
   assign x_wrap    = pix_x == 10'(H_RES - 1);
   assign last_pix  = x_wrap && pix_y == 9'(V_RES - 1);
   assign busy      = state == ISSUE || state == DRAIN;
   assign done      = state == FINISH;
   assign pix_z     = 6'(Z_PLANE);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? ISSUE : IDLE;
         ISSUE:   state_nx = pix_valid && last_pix ? DRAIN : ISSUE;
         DRAIN:   state_nx = inflight == '0 && fifo_count == CW'(pop) ? FINISH : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         vsr        <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         addr       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         state <= state_nx;
         vsr   <= (vsr << 1) | CORE_LATENCY'(pix_valid);
         if (state == IDLE && start) begin
            pix_x <= '0;
            pix_y <= '0;
            addr  <= '0;
         end else if (pix_valid) begin
            addr  <= addr + ADDR_W'(1);
            pix_x <= x_wrap ? '0 : pix_x + 10'd1;
            pix_y <= !x_wrap ? pix_y : last_pix ? '0 : pix_y + 9'd1;
         end
         wr_ptr     <= !push ? wr_ptr : wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
         rd_ptr     <= !pop ? rd_ptr : rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      asr[0] <= addr;
      for (int i = 1; i < CORE_LATENCY; i++) asr[i] <= asr[i-1];
      if (push) mem[wr_ptr] <= {asr[CORE_LATENCY-1], ~core_ltz};
   end
   assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: tb/tb_raytrace_frame_ctrl.sv
// tb_raytrace_frame_ctrl: scoreboard bench for a 4x3 frame under several fb_ready patterns and a mid-frame reset.
module tb_raytrace_frame_ctrl;
   logic clk = 0, rst = 1, start = 0, fb_ready = 1, core_ltz;
   logic busy, done, pix_valid, fb_we, fb_data;
   logic [9:0] pix_x;
   logic [8:0] pix_y;
   logic [5:0] pix_z;
   logic [3:0] fb_addr;
   logic [3:0] cm = '0;
   int q[$];
   int checks = 0, errors = 0, done_cnt = 0, issue_cnt = 0, done_cyc = 0, last_acc = 0;
   longint ts = 0;

   raytrace_frame_ctrl #(.H_RES(4), .V_RES(3), .Z_PLANE(31), .CORE_LATENCY(4),
                         .FIFO_DEPTH(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_z(pix_z),
      .core_ltz(core_ltz), .fb_we(fb_we), .fb_ready(fb_ready),
      .fb_addr(fb_addr), .fb_data(fb_data));

   always #5 clk = ~clk;

   // Core stand-in: ltz = (x+y) odd, four cycles after issue.
   always @(posedge clk) cm <= {cm[2:0], 1'((int'(pix_x) + int'(pix_y)) & 1)};
   assign core_ltz = cm[3];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cyc_now();
      return int'(($time - ts + 5) / 10);
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (fb_we && fb_ready) begin
            if (q.size() == 0) chk("unexpected_write", int'(fb_addr), -1);
            else begin
               int e;
               e = q.pop_front();
               chk("fb_addr", int'(fb_addr), e >> 1);
               chk("fb_data", int'(fb_data), e & 1);
               last_acc = cyc_now();
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc_now();
         end
         if (pix_valid) issue_cnt++;
      end
   end

   function automatic logic ready_for(input int mode, input int k);
      return mode == 0 ? 1'b1 : mode == 1 ? !(k >= 2 && k < 22) : 1'((k + 1) % 2);
   endfunction

   task automatic frame(input int mode, input int rst_at, input bit restart);
      int k;
      for (int i = 0; i < 12; i++) q.push_back(i * 2 + int'(((i % 4) + (i / 4)) % 2 == 0));
      done_cnt = 0;
      issue_cnt = 0;
      @(posedge clk);
      #1 start = 1;
      fb_ready = 1;
      @(posedge clk);
      ts = $time;
      #1 start = 0;
      for (k = 1; k < 300 && done_cnt == 0; k++) begin
         fb_ready = ready_for(mode, k);
         start = restart && k == 3;
         if (mode == 1 && k == 21) begin
            chk("stalled_issue_count", issue_cnt, 8);
            chk("stalled_fifo_count", int'(dut.fifo_count), 8);
         end
         if (k == rst_at) begin
            rst = 1;
            #1;
            chk("rst_pix_valid", int'(pix_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_fb_we", int'(fb_we), 0);
            chk("rst_fb_addr", int'(fb_addr), 0);
            chk("rst_pix_x", int'(pix_x), 0);
            q.delete();
            repeat (2) @(posedge clk);
            #1 rst = 0;
            chk("rst_no_done", done_cnt, 0);
            return;
         end
         @(posedge clk);
         #1;
      end
      start = 0;
      fb_ready = 1;
      chk("done_seen", done_cnt, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_after", int'(busy), 0);
      chk("single_done", done_cnt, 1);
      chk("queue_empty", q.size(), 0);
      chk("issue_total", issue_cnt, 12);
      chk("done_after_last_write", done_cyc, last_acc + 1);
      if (mode == 0) chk("done_cycle", done_cyc, 18);
   endtask

   initial begin
      #12;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_pix_valid", int'(pix_valid), 0);
      chk("reset_fb_we", int'(fb_we), 0);
      chk("reset_fb_addr", int'(fb_addr), 0);
      chk("pix_z", int'(pix_z), 31);
      @(posedge clk);
      #1 rst = 0;
      frame(0, 0, 0);
      frame(1, 0, 0);
      frame(2, 0, 0);
      frame(0, 0, 1);
      frame(0, 7, 0);
      frame(0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/raytrace_frame_ctrl.md
Name: raytrace_frame_ctrl

Overview:
Frame scheduler for RayTraceCore. On start it walks every pixel of the frame in raster order, presents one pixel per cycle to the free-running core pipeline, and tracks in-flight pixels by address. It collects each core result into a small result FIFO and drains it to the framebuffer over a valid/ready write port. Issue is throttled by credits so a non-stallable core never overflows the FIFO when the framebuffer back-pressures.

Parameters:
H_RES, 640, pixels per line (x range 0..H_RES-1)
V_RES, 480, lines per frame (y range 0..V_RES-1)
Z_PLANE, 31, constant value driven on pix_z
CORE_LATENCY, 4, cycles from pix_valid/pix_x/pix_y to matching core_ltz; must be >=1
FIFO_DEPTH, 8, result FIFO entries; must be >= CORE_LATENCY+1
ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: begin a frame (sampled only in IDLE)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the last framebuffer write is accepted
pix_valid  out  1  pixel presented to core this cycle
pix_x  out  10  pixel x to core
pix_y  out  9  pixel y to core
pix_z  out  6  pixel z to core (constant Z_PLANE)
core_ltz  in  1  core less_than_zero, aligned CORE_LATENCY cycles after issue
fb_we  out  1  write valid (FIFO non-empty)
fb_ready  in  1  framebuffer accepts write when fb_we && fb_ready
fb_addr  out  ADDR_W  write address = y*H_RES + x of the pixel
fb_data  out  1  hit bit = ~core_ltz (negative discriminant = miss)

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, pix_valid=0, pix_x=0, pix_y=0, fb_we=0, fb_addr=0, fb_data=0; FIFO emptied; in-flight shift register cleared; all counters 0. pix_z is always Z_PLANE.
- FSM: IDLE -> ISSUE on start. ISSUE -> DRAIN the cycle after the last pixel (H_RES-1, V_RES-1) issues. DRAIN -> DONE when the in-flight count is 0, the FIFO is empty, and the last write has been accepted. DONE -> IDLE unconditionally after 1 cycle, with done=1 during the DONE cycle. start is ignored outside IDLE.
- Issue rule (ISSUE only): pix_valid=1 iff fifo_count + inflight_count < FIFO_DEPTH. inflight_count = number of set bits in a CORE_LATENCY-deep valid shift register. Raster advance happens only on an issue cycle: x++, and at x=H_RES-1, x wraps to 0 and y++.
- Address: a parallel address shift register carries a running linear address, incremented per issue (no multiplier). The first pixel is address 0 and the last is H_RES*V_RES-1.
- Capture: when the valid shift-register output is 1, push {addr, ~core_ltz} into the FIFO that edge. A push never finds the FIFO full, guaranteed by credits. Overflow is a design error; assert it in simulation.
- Drain: fb_we = !empty; fb_addr and fb_data come from the FIFO head. Pop on fb_we && fb_ready. Push and pop in the same cycle leave the count unchanged, including at empty (push only) and at full-minus-one.
- Throughput: with fb_ready held at 1, one pixel issues per cycle. The frame completes in H_RES*V_RES + CORE_LATENCY + 2 cycles from start to done.
- Writes are emitted strictly in raster order. There are no gaps or duplicates.
- fb_ready low for any duration: issue stalls once credits are exhausted. Results already in flight land in the FIFO without loss.
- Reset mid-frame: everything aborts immediately. done does not pulse. The next start restarts at pixel (0,0), address 0.

Test Plan:
- H_RES=4, V_RES=3, CORE_LATENCY=4, fb_ready=1, model core as ltz=(x+y odd) delayed 4 cycles; pulse start -> 12 writes addr 0..11 in order, data=~((x+y)&1), done pulses once at cycle 18 after start, busy low after.
- Same config, fb_ready=0 for 20 cycles from cycle 2 -> pix_valid stops after exactly FIFO_DEPTH total issues, fifo_count reaches 8 without overflow, all 12 writes later correct and ordered.
- fb_ready toggling 1/0 every cycle -> one write per 2 cycles, no duplicates or losses, done after the 12th accepted write.
- start pulsed again during ISSUE -> ignored; exactly 12 writes, single done.
- Assert rst at cycle 7 mid-frame -> all outputs 0 the same cycle (async), no done; new start -> first write addr 0.
- Default params (640x480), fb_ready=1 -> 307200 writes, last addr 307199, done at cycle 307206.
